// File: rtl/cache_lru_part_pkg.sv
// Shared types and default sizing for the partitioned LRU replacement engine.
package cache_lru_part_pkg;

    typedef enum logic {
        Single_Threaded = 1'b0,
        Multi_Threaded  = 1'b1
    } multithreading_mode_t;

    typedef enum logic {
        LRU_INIT = 1'b0,
        LRU_IDLE = 1'b1
    } lru_fsm_t;

    localparam int ICACHE_NUM_SET      = 64;
    localparam int ICACHE_WAYS_PER_SET = 4;
    localparam int THR_PER_CORE        = 2;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_part_set.sv
// Age permutation for one set; ages form {0..P-1} within every partition.
module cache_lru_part_set
    import cache_lru_part_pkg::*;
#(
    parameter  int WAYS_PER_SET   = 4,
    parameter  int NUM_THREADS    = 2,
    localparam int WPT            = WAYS_PER_SET / NUM_THREADS,
    localparam int WAYS_PER_SET_W = clog2_min1(WAYS_PER_SET)
) (
    input  logic                                          clock,
    input  multithreading_mode_t                          mode,
    input  logic                                          init,
    input  logic                                          touch,
    input  logic [WAYS_PER_SET_W-1:0]                     touch_way,
    input  logic                                          inval,
    input  logic [WAYS_PER_SET_W-1:0]                     inval_way,
    output logic [NUM_THREADS-1:0][WAYS_PER_SET_W-1:0]    victim
);

    logic [WAYS_PER_SET_W-1:0] age [WAYS_PER_SET];
    logic                      mt;
    logic [WAYS_PER_SET_W-1:0] last_age;

    assign mt       = (mode == Multi_Threaded);
    assign last_age = mt ? WAYS_PER_SET_W'(WPT - 1) : WAYS_PER_SET_W'(WAYS_PER_SET - 1);

    // True when way i shares a partition with way w in the current mode.
    function automatic logic same_part(input logic is_mt, input int i, input logic [WAYS_PER_SET_W-1:0] w);
        return !is_mt || ((i / WPT) == (int'(w) / WPT));
    endfunction

    // Age update: init sweep, then invalidate (make oldest), then touch (make newest).
    // NOTE: the age array has no reset; the init sweep writes every set before ready rises.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS_PER_SET; i++) begin
            if (init) begin
                age[i] <= mt ? WAYS_PER_SET_W'(i % WPT) : WAYS_PER_SET_W'(i);
            end else if (inval) begin
                if (same_part(mt, i, inval_way)) begin
                    if (WAYS_PER_SET_W'(i) == inval_way)
                        age[i] <= last_age;
                    else if (age[i] > age[inval_way])
                        age[i] <= age[i] - 1'b1;
                end
            end else if (touch) begin
                if (same_part(mt, i, touch_way)) begin
                    if (WAYS_PER_SET_W'(i) == touch_way)
                        age[i] <= '0;
                    else if (age[i] < age[touch_way])
                        age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // Victim per thread: the unique way of its partition holding the oldest age.
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            victim[t] = '0;
            for (int i = 0; i < WAYS_PER_SET; i++) begin
                if ((!mt || (i / WPT) == t) && age[i] == last_age)
                    victim[t] = WAYS_PER_SET_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_lru_part.sv
// Partitioned LRU engine: init-sweep FSM, request arbitration, registered victim.
module cache_lru_part
    import cache_lru_part_pkg::*;
#(
    parameter  int NUM_SET        = ICACHE_NUM_SET,
    parameter  int WAYS_PER_SET   = ICACHE_WAYS_PER_SET,
    parameter  int NUM_THREADS    = THR_PER_CORE,
    localparam int NUM_SET_W      = clog2_min1(NUM_SET),
    localparam int WAYS_PER_SET_W = clog2_min1(WAYS_PER_SET),
    localparam int THR_W          = clog2_min1(NUM_THREADS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  multithreading_mode_t      mt_mode,
    output logic                      ready,
    input  logic                      victim_req,
    input  logic [NUM_SET_W-1:0]      victim_set,
    input  logic [THR_W-1:0]          victim_thread,
    output logic                      victim_valid,
    output logic [WAYS_PER_SET_W-1:0] victim_way,
    input  logic                      update_req,
    input  logic [NUM_SET_W-1:0]      update_set,
    input  logic [WAYS_PER_SET_W-1:0] update_way,
    input  logic                      inval_req,
    input  logic [NUM_SET_W-1:0]      inval_set,
    input  logic [WAYS_PER_SET_W-1:0] inval_way
);

    lru_fsm_t             state, state_next;
    logic [NUM_SET_W-1:0] sweep_ptr, ptr_next;
    multithreading_mode_t mt_mode_ff;
    logic                 mode_change;
    logic                 same_set_conflict;
    logic [THR_W-1:0]     thread_sel;

    logic [NUM_SET-1:0] init_strobe, touch_strobe, inval_strobe;
    logic [NUM_SET-1:0][NUM_THREADS-1:0][WAYS_PER_SET_W-1:0] set_victim;

    // Next-state logic: sweep sets one per cycle, restart the sweep on a mode change.
    always_comb begin
        state_next  = state;
        ptr_next    = sweep_ptr;
        ready       = 1'b0;
        mode_change = 1'b0;
        unique case (state)
            LRU_INIT: begin
                if (sweep_ptr == NUM_SET_W'(NUM_SET - 1)) begin
                    state_next = LRU_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = sweep_ptr + 1'b1;
                end
            end
            LRU_IDLE: begin
                ready = 1'b1;
                if (mt_mode != mt_mode_ff) begin
                    mode_change = 1'b1;
                    state_next  = LRU_INIT;
                    ptr_next    = '0;
                end
            end
            default: state_next = LRU_INIT;
        endcase
    end

    // An invalidate wins over an update aimed at the same set.
    assign same_set_conflict = update_req && inval_req && (update_set == inval_set);
    assign thread_sel        = (mt_mode_ff == Multi_Threaded) ? victim_thread : '0;

    for (genvar s = 0; s < NUM_SET; s++) begin : g_set
        assign init_strobe[s]  = (state == LRU_INIT) && (sweep_ptr == NUM_SET_W'(s));
        assign touch_strobe[s] = ready && update_req && !same_set_conflict && (update_set == NUM_SET_W'(s));
        assign inval_strobe[s] = ready && inval_req && (inval_set == NUM_SET_W'(s));

        cache_lru_part_set #(
            .WAYS_PER_SET (WAYS_PER_SET),
            .NUM_THREADS  (NUM_THREADS)
        ) u_set (
            .clock     (clock),
            .mode      (mt_mode_ff),
            .init      (init_strobe[s]),
            .touch     (touch_strobe[s]),
            .touch_way (update_way),
            .inval     (inval_strobe[s]),
            .inval_way (inval_way),
            .victim    (set_victim[s])
        );
    end

    // State register, mode latch and registered victim response.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= LRU_INIT;
            sweep_ptr    <= '0;
            mt_mode_ff   <= mt_mode;
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            state        <= state_next;
            sweep_ptr    <= ptr_next;
            if (mode_change)
                mt_mode_ff <= mt_mode;
            victim_valid <= ready && victim_req;
            if (ready && victim_req)
                victim_way <= set_victim[victim_set][thread_sel];
        end
    end

endmodule

// File: tb/tb_cache_lru_part.sv
// Directed table-driven bench for cache_lru_part (4 sets, 4 ways, 2 threads).
module tb_cache_lru_part;
    import cache_lru_part_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    multithreading_mode_t mt_mode;
    logic                 ready;
    logic                 victim_req;
    logic [1:0]           victim_set;
    logic                 victim_thread;
    logic                 victim_valid;
    logic [1:0]           victim_way;
    logic                 update_req;
    logic [1:0]           update_set;
    logic [1:0]           update_way;
    logic                 inval_req;
    logic [1:0]           inval_set;
    logic [1:0]           inval_way;

    int checks = 0;
    int errors = 0;

    cache_lru_part #(
        .NUM_SET      (4),
        .WAYS_PER_SET (4),
        .NUM_THREADS  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mt_mode       (mt_mode),
        .ready         (ready),
        .victim_req    (victim_req),
        .victim_set    (victim_set),
        .victim_thread (victim_thread),
        .victim_valid  (victim_valid),
        .victim_way    (victim_way),
        .update_req    (update_req),
        .update_set    (update_set),
        .update_way    (update_way),
        .inval_req     (inval_req),
        .inval_set     (inval_set),
        .inval_way     (inval_way)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       vr;
        logic [1:0] vs;
        logic       vt;
        logic       ur;
        logic [1:0] us;
        logic [1:0] uw;
        logic       ir;
        logic [1:0] iset;
        logic [1:0] iw;
        logic       ev;
        logic [1:0] ew;
    } vec_t;

    vec_t st_vecs[$];
    vec_t mt_vecs[$];

    function automatic vec_t mk(input logic vr, input int vs, input int vt,
                                input logic ur, input int us, input int uw,
                                input logic ir, input int iset, input int iw,
                                input logic ev, input int ew);
        vec_t v;
        v.vr = vr; v.vs = 2'(vs); v.vt = 1'(vt);
        v.ur = ur; v.us = 2'(us); v.uw = 2'(uw);
        v.ir = ir; v.iset = 2'(iset); v.iw = 2'(iw);
        v.ev = ev; v.ew = 2'(ew);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        victim_req = 1'b0; victim_set = '0; victim_thread = 1'b0;
        update_req = 1'b0; update_set = '0; update_way = '0;
        inval_req  = 1'b0; inval_set  = '0; inval_way  = '0;
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        victim_req = v.vr; victim_set = v.vs; victim_thread = v.vt;
        update_req = v.ur; update_set = v.us; update_way = v.uw;
        inval_req  = v.ir; inval_set  = v.iset; inval_way = v.iw;
        step();
        check($sformatf("%s[%0d] victim_valid", tag, idx), 32'(victim_valid), 32'(v.ev));
        check($sformatf("%s[%0d] victim_way", tag, idx), 32'(victim_way), 32'(v.ew));
        clear_inputs();
    endtask

    initial begin
        // ST after fresh sweep: every set starts with age[w] = w, victim way 3.
        st_vecs.push_back(mk(1,2,0, 0,0,0, 0,0,0, 1,3)); // victim set 2
        st_vecs.push_back(mk(0,0,0, 1,0,3, 0,0,0, 0,3)); // touch 3 -> [1,2,3,0]
        st_vecs.push_back(mk(0,0,0, 1,0,2, 0,0,0, 0,3)); // touch 2 -> [2,3,0,1]
        st_vecs.push_back(mk(0,0,0, 1,0,1, 0,0,0, 0,3)); // touch 1 -> [3,0,1,2]
        st_vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0, 1,0));
        st_vecs.push_back(mk(0,0,0, 1,0,0, 0,0,0, 0,0)); // touch 0 -> [0,1,2,3]
        st_vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0, 1,3));
        st_vecs.push_back(mk(0,0,0, 0,0,0, 1,0,1, 0,3)); // inval 1 -> [0,3,1,2]
        st_vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0, 1,1));
        st_vecs.push_back(mk(0,0,0, 1,0,1, 0,0,0, 0,1)); // touch 1 -> [1,0,2,3]
        st_vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0, 1,3));
        st_vecs.push_back(mk(0,0,0, 1,1,3, 1,2,0, 0,3)); // different sets: both applied
        st_vecs.push_back(mk(1,1,0, 0,0,0, 0,0,0, 1,2)); // set1 [1,2,3,0]
        st_vecs.push_back(mk(1,2,0, 0,0,0, 0,0,0, 1,0)); // set2 [3,0,1,2]
        st_vecs.push_back(mk(0,0,0, 1,3,3, 1,3,0, 0,0)); // same set: inval only -> [3,0,1,2]
        st_vecs.push_back(mk(1,3,0, 0,0,0, 0,0,0, 1,0));
        st_vecs.push_back(mk(1,3,0, 1,3,0, 0,0,0, 1,0)); // victim sees pre-touch ages
        st_vecs.push_back(mk(1,3,0, 0,0,0, 0,0,0, 1,3)); // after touch 0 -> [0,1,2,3]
        st_vecs.push_back(mk(1,2,0, 0,0,0, 1,2,3, 1,0)); // victim sees pre-inval ages
        st_vecs.push_back(mk(1,2,0, 0,0,0, 0,0,0, 1,3)); // set2 [2,0,1,3]

        // MT after fresh sweep: every set starts with ages [0,1,0,1].
        mt_vecs.push_back(mk(1,1,1, 0,0,0, 0,0,0, 1,3));
        mt_vecs.push_back(mk(0,0,0, 1,1,3, 0,0,0, 0,3)); // set1 [0,1,1,0]
        mt_vecs.push_back(mk(1,1,1, 0,0,0, 0,0,0, 1,2));
        mt_vecs.push_back(mk(1,1,0, 0,0,0, 0,0,0, 1,1));
        mt_vecs.push_back(mk(0,0,0, 1,1,1, 0,0,0, 0,1)); // set1 [1,0,1,0]
        mt_vecs.push_back(mk(1,1,0, 0,0,0, 0,0,0, 1,0));
        mt_vecs.push_back(mk(1,1,1, 0,0,0, 0,0,0, 1,2));
        mt_vecs.push_back(mk(0,0,0, 0,0,0, 1,0,2, 0,2)); // set0 [0,1,1,0]
        mt_vecs.push_back(mk(1,0,1, 0,0,0, 0,0,0, 1,2));
        mt_vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0, 1,1));

        clear_inputs();
        mt_mode = Single_Threaded;

        // Reset for two cycles, ST mode.
        reset = 1'b1;
        step();
        step();
        check("reset ready", 32'(ready), 32'd0);
        check("reset victim_valid", 32'(victim_valid), 32'd0);
        check("reset victim_way", 32'(victim_way), 32'd0);
        reset = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("st sweep ready k=%0d", k), 32'(ready), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) step();
        end

        for (int i = 0; i < st_vecs.size(); i++) apply(st_vecs[i], "st", i);

        // Switch to MT: ready stays high this cycle, then drops for the 4-cycle sweep.
        mt_mode = Multi_Threaded;
        check("mode change cycle ready", 32'(ready), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("mt sweep ready k=%0d", k), 32'(ready), (k == 5) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < mt_vecs.size(); i++) apply(mt_vecs[i], "mt", i);

        // Reset pulsed mid-sweep at ptr=2; requests during the sweep are ignored.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("mid sweep ready", 32'(ready), 32'd0);
        reset = 1'b1;
        victim_req = 1'b1;
        victim_set = 2'd0;
        victim_thread = 1'b1;
        update_req = 1'b1;
        update_set = 2'd0;
        update_way = 2'd3;
        step();
        reset = 1'b0;
        check("restart ready k=0", 32'(ready), 32'd0);
        check("restart victim_valid k=0", 32'(victim_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("restart ready k=%0d", k), 32'(ready), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("restart victim_valid k=%0d", k), 32'(victim_valid), 32'd0);
        end
        clear_inputs();
        step();
        check("post restart idle victim_valid", 32'(victim_valid), 32'd0);
        apply(mk(1,0,1, 0,0,0, 0,0,0, 1,3), "post restart", 0);
        apply(mk(1,0,0, 0,0,0, 0,0,0, 1,1), "post restart", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
